apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
APB initiator that turns a simple command/response interface into APB3 transfers with SETUP and ACCESS phases. It is the requester side for the block's APB register slaves, e.g. a PULP-side control sequencer writing the LSTM accelerator control register and polling status. One transfer is outstanding at a time. Wait states are honoured, PSLVERR is reported, and a transfer that never completes is aborted after a programmable timeout.

Parameters:
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
rsp_timeout  out  1  transfer aborted by timeout, valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK. On reset, state=IDLE and every output is 0, including cmd_ready, rsp_*, PSEL, PENABLE, PWRITE, PADDR and PWDATA. cmd_ready rises in the first cycle after reset release.
- All outputs are registered, except cmd_ready, which is decoded as (state==IDLE).
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid&cmd_ready, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0, lasting exactly 1 cycle. Clear the wait counter, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PWRITE, PADDR and PWDATA stay stable from SETUP until completion.
- Normal completion: at the ACCESS edge where PREADY=1, go to IDLE. In the next cycle assert rsp_valid=1 for 1 cycle with these values:
  - rsp_rdata = PRDATA if read, else 0
  - rsp_err = PSLVERR
  - rsp_timeout = 0
- Timeout: in ACCESS with PREADY=0, the wait counter increments. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 while PREADY=0, abort at that edge: go to IDLE, drop PSEL and PENABLE, and pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. An abort therefore happens after exactly TIMEOUT_CYCLES ACCESS cycles. PREADY=1 on that same edge wins and gives normal completion.
- When sampled: PRDATA and PSLVERR are sampled only at the completing edge and ignored otherwise.
- Counter sizing: the wait counter is wide enough for TIMEOUT_CYCLES and must never wrap. With TIMEOUT_CYCLES=0 the block waits indefinitely.
- Outside rsp_valid cycles: rsp_rdata, rsp_err and rsp_timeout are 0.
- Throughput: rsp_valid and cmd_ready are both high in the cycle after completion, so a new command can be accepted in that cycle. Minimum rate is 3 cycles per transfer (IDLE, SETUP, ACCESS).
- In IDLE, PADDR, PWDATA and PWRITE hold their last values.
- Commands in flight: cmd_valid outside IDLE is ignored and not queued.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously, no rsp_valid is issued, and the FSM restarts in IDLE.

Test Plan:
- Write 0xDEADBEEF to addr 0x00, PREADY tied 1 -> PSEL high 2 cycles (PENABLE only in the 2nd), PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid the next cycle with rsp_err=0 and rsp_rdata=0.
- Read addr 0x01 with PREADY low for 2 ACCESS cycles, slave returning 0x0000_00A5 -> ACCESS lasts 3 cycles; rsp_rdata=0xA5, rsp_err=0.
- Read with PSLVERR=1 at the PREADY edge -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, PREADY held 0 -> abort after exactly 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 afterwards. Also drive PREADY=1 on the 4th cycle -> normal completion instead.
- 4 back-to-back commands (writes to 0x00/0x01, reads from 0x00/0x01) with cmd_valid held high and PREADY tied 1 -> one transfer every 3 cycles; read of 0x00 returns the written value.
- Assert PRESETn low during ACCESS -> PSEL, PENABLE and rsp_valid are 0 immediately; after release a new write completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// Command/response and APB3 bus bundle for apb_master.
// master modport is the initiator view; slave modport is the opposite side (bus model or requester/slave pair).
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB3 initiator: one outstanding command turned into SETUP+ACCESS, with wait states, PSLVERR and timeout abort.
// Latency: response pulse one cycle after the completing ACCESS edge; minimum 3 cycles per transfer.
// Backpressure: cmd_ready only in IDLE; cmd_valid outside IDLE is ignored, responses cannot be stalled.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_rst_done;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_to;
    logic                  w_cmd_rdy;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_abort;

    // cmd_ready stays low while reset is held and rises one edge after release
    assign w_cmd_rdy = r_rst_done && (r_state == IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && w_cmd_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                // PREADY on the final wait cycle wins over the abort
                if (bus.PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (TO_EN && (r_wait_cnt == CNT_LAST)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cnt  <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_psel    <= (w_state_nxt != IDLE);
            r_penable <= (w_state_nxt == ACCESS);
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
            // saturates so an unbounded wait never wraps into a false abort
            if (r_state == SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ACCESS) && !bus.PREADY && (r_wait_cnt != CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_rsp_vld   <= w_done || w_abort;
            r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
            r_rsp_err   <= (w_done && bus.PSLVERR) || w_abort;
            r_rsp_to    <= w_abort;
        end
    end

    assign bus.cmd_ready   = w_cmd_rdy;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_vld;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_to;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios then random transfers against a memory-based reference model.
module tb_apb_master;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;
    int rsp_gap = 0;
    logic [DW-1:0] slave_mem [0:255];
    logic [DW-1:0] ref_mem   [0:255];

    always @(posedge PCLK) cyc++;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command; the bench plays the APB slave and checks the transfer shape and response.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic serr);
        int n_setup = 0;
        int n_acc = 0;
        int budget = 0;
        bit got = 0, bad_hold = 0, bad_rdy = 0, bad_rsp = 0;
        bit exp_to;
        int exp_acc;
        logic [DW-1:0] exp_rd;
        logic exp_err;
        exp_to  = (waits >= TO);
        exp_acc = exp_to ? TO : waits + 1;
        exp_rd  = (exp_to || w) ? '0 : ref_mem[a];
        exp_err = exp_to ? 1'b1 : serr;
        if (!exp_to && w && !serr) ref_mem[a] = d;

        chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.PREADY    = 1'b0;
        while (!got && budget < 60) begin
            @(posedge PCLK); #1;
            budget++;
            // keep presenting junk commands; they must be ignored outside IDLE
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_wdata = $urandom;
            bus.PREADY    = 1'($urandom);
            bus.PSLVERR   = 1'($urandom);
            bus.PRDATA    = $urandom;
            if (bus.rsp_valid) begin
                got = 1;
            end else begin
                if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) bad_rsp = 1;
                if (bus.PSEL) begin
                    if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== d) bad_hold = 1;
                    if (bus.cmd_ready !== 1'b0) bad_rdy = 1;
                    if (!bus.PENABLE) begin
                        n_setup++;
                    end else begin
                        n_acc++;
                        bus.PREADY = (n_acc > waits);
                        if (bus.PREADY) begin
                            bus.PSLVERR = serr;
                            bus.PRDATA  = slave_mem[bus.PADDR];
                            if (bus.PWRITE && !serr) slave_mem[bus.PADDR] = bus.PWDATA;
                        end
                    end
                end
            end
        end
        bus.cmd_valid = 1'b0;
        chk("rsp_seen", {31'd0, got}, 1);
        rsp_gap      = cyc - last_rsp_cyc;
        last_rsp_cyc = cyc;
        chk("rsp_rdata",   bus.rsp_rdata, exp_rd);
        chk("rsp_err",     {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp_to});
        chk("psel_after",  {30'd0, bus.PSEL, bus.PENABLE}, 0);
        chk("cmd_ready_after", {31'd0, bus.cmd_ready}, 1);
        chk("setup_cycles",  n_setup, 1);
        chk("access_cycles", n_acc, exp_acc);
        chk("addr_data_stable", {31'd0, bad_hold}, 0);
        chk("cmd_ready_busy", {31'd0, bad_rdy}, 0);
        chk("rsp_zero_idle", {31'd0, bad_rsp}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        bit psel_seen;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // reset state
        #12;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
        chk("rst_psel_pen",  {30'd0, bus.PSEL, bus.PENABLE}, 0);
        chk("rst_pwrite",    {31'd0, bus.PWRITE}, 0);
        chk("rst_paddr",     {24'd0, bus.PADDR}, 0);
        chk("rst_pwdata",    bus.PWDATA, 0);
        chk("rst_rsp",       {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
        chk("rst_rdata",     bus.rsp_rdata, 0);
        PRESETn = 1'b1;
        #1;
        chk("rel_cmd_ready_pre", {31'd0, bus.cmd_ready}, 0);
        @(posedge PCLK); #1;

        // directed
        xfer(1'b1, 8'h00, 32'hDEADBEEF, 0, 1'b0);
        slave_mem[1] = 32'h0000_00A5;
        ref_mem[1]   = 32'h0000_00A5;
        xfer(1'b0, 8'h01, 32'h1234_5678, 2, 1'b0);
        xfer(1'b0, 8'h02, 32'h0, 1, 1'b1);
        xfer(1'b0, 8'h01, 32'h0, 10, 1'b0);
        xfer(1'b0, 8'h01, 32'h0, 3, 1'b0);
        xfer(1'b1, 8'h03, 32'hCAFE_F00D, TO, 1'b0);
        xfer(1'b0, 8'h03, 32'h0, 0, 1'b0);

        // back-to-back: command presented in the response cycle
        xfer(1'b1, 8'h00, 32'h1111_2222, 0, 1'b0);
        xfer(1'b1, 8'h01, 32'h3333_4444, 0, 1'b0);
        chk("b2b_gap1", rsp_gap, 3);
        xfer(1'b0, 8'h00, 32'h0, 0, 1'b0);
        chk("b2b_gap2", rsp_gap, 3);
        xfer(1'b0, 8'h01, 32'h0, 0, 1'b0);
        chk("b2b_gap3", rsp_gap, 3);
        psel_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            if (bus.PSEL !== 1'b0) psel_seen = 1;
        end
        chk("no_queued_cmd", {31'd0, psel_seen}, 0);

        // reset during ACCESS
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h05;
        bus.PREADY    = 1'b0;
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        chk("mid_access_reached", {30'd0, bus.PSEL, bus.PENABLE}, 3);
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel_pen", {30'd0, bus.PSEL, bus.PENABLE}, 0);
        chk("mid_rst_rsp", {31'd0, bus.rsp_valid}, 0);
        @(posedge PCLK); #1;
        chk("mid_rst_rsp_hold", {31'd0, bus.rsp_valid}, 0);
        #2 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b1, 8'h06, 32'h5A5A_0F0F, 1, 1'b0);
        xfer(1'b0, 8'h06, 32'h0, 0, 1'b0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge PCLK); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
